// File: rtl/fifo_pkg.sv
// Shared definitions for the sync FIFO family.
// Read-mode constants and the occupancy-counter width helper.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_dp_ram.sv
// Single-clock dual-port RAM, one write and one registered read port.
// The array is never reset; only the read data register is.
module sync_dp_ram #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    // Storage write; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; holds its value when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, thresholds, sticky errors
// and a selectable first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    parameter int FWFT      = FIFO_STD
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr,
    input  logic [DATAWIDTH-1:0]          Wdata,
    input  logic                          rd,
    output logic [DATAWIDTH-1:0]          Rdata,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int ADDR = $clog2(DEPTH);
    localparam int CW   = cnt_width(DEPTH);
    localparam bit MODE_FWFT = (FWFT == FIFO_FWFT);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AEMPTY_TH);

    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic          r_ovf;
    logic          r_unf;
    logic          r_out_valid;

    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_ram_has;
    logic          w_fetch;
    logic          w_ram_re;
    logic [CW-1:0] w_count_next;
    logic          w_out_valid_next;
    logic          w_ovf_next;
    logic          w_unf_next;

    // Acceptance, prefetch and next-state decode.
    always_comb begin
        w_empty          = MODE_FWFT ? !r_out_valid : r_empty;
        w_wr_acc         = wr && !r_full;
        w_rd_acc         = rd && !w_empty;
        // In FWFT the read pointer tracks RAM reads, so this means
        // "RAM holds a word not yet moved to the output stage".
        w_ram_has        = (r_wr_ptr != r_rd_ptr);
        w_fetch          = w_ram_has && (!r_out_valid || w_rd_acc);
        w_ram_re         = MODE_FWFT ? w_fetch : w_rd_acc;
        w_count_next     = r_count;
        w_out_valid_next = 1'b0;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_next = r_count + ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_next = r_count - ONE;
        end
        if (MODE_FWFT) begin
            if (w_fetch) begin
                w_out_valid_next = 1'b1;
            end else if (w_rd_acc) begin
                w_out_valid_next = 1'b0;
            end else begin
                w_out_valid_next = r_out_valid;
            end
        end
        // Setting an error wins over a coincident clear.
        w_ovf_next = (r_ovf && !clr_err) || (wr && r_full);
        w_unf_next = (r_unf && !clr_err) || (rd && w_empty);
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_ram_re) begin
                r_rd_ptr <= r_rd_ptr + ONE;
            end
            r_count     <= w_count_next;
            r_full      <= (w_count_next == FULL_CNT);
            r_empty     <= (w_count_next == '0);
            r_afull     <= (w_count_next >= AF_CNT);
            r_aempty    <= (w_count_next <= AE_CNT);
            r_ovf       <= w_ovf_next;
            r_unf       <= w_unf_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    // The RAM read register doubles as Rdata and the FWFT output stage.
    sync_dp_ram #(
        .DW(DATAWIDTH),
        .AW(ADDR)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_wr_acc),
        .i_waddr(r_wr_ptr[ADDR-1:0]),
        .i_wdata(Wdata),
        .i_re   (w_ram_re),
        .i_raddr(r_rd_ptr[ADDR-1:0]),
        .o_rdata(Rdata)
    );

    assign full         = r_full;
    assign empty        = w_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param in standard and FWFT modes.
// Both instances share stimulus; each test resets first.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] Wdata = 8'h00;

    logic [7:0] s_rdata, f_rdata;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] s_count, f_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATAWIDTH(8), .DEPTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr(wr), .Wdata(Wdata), .rd(rd),
        .Rdata(s_rdata), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_param #(.DATAWIDTH(8), .DEPTH(8), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wr(wr), .Wdata(Wdata), .rd(rd),
        .Rdata(f_rdata), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr = 1'b0;
        rd = 1'b0;
        clr_err = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        do_reset();
        // {full,empty,af,ae,count,ovf,unf,rdata==0}
        got = {s_full, s_empty, s_af, s_ae, s_count,
               s_ovf, s_unf, (s_rdata == 8'h00), 3'b000};
        n_total++;
        if (got !== 14'b0_1_0_1_0000_0_0_1_000)
            $display("FAIL std_reset_state got=%b want=%b",
                     got, 14'b0_1_0_1_0000_0_0_1_000);
        else n_pass++;
        got = {f_full, f_empty, f_af, f_ae, f_count,
               f_ovf, f_unf, (f_rdata == 8'h00), 3'b000};
        n_total++;
        if (got !== 14'b0_1_0_1_0000_0_0_1_000)
            $display("FAIL fwft_reset_state got=%b want=%b",
                     got, 14'b0_1_0_1_0000_0_0_1_000);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [2:0] got, exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1;
            Wdata = 8'h11 + 8'(i);
            step();
            n_total++;
            if (s_count !== 4'(i + 1))
                $display("FAIL fill_count[%0d] got=%0d want=%0d",
                         i, s_count, i + 1);
            else n_pass++;
            got = {s_full, s_af, s_ae};
            exp = {(i == 7), (i >= 6), (i == 0)};
            n_total++;
            if (got !== exp)
                $display("FAIL fill_flags[%0d] got=%b want=%b",
                         i, got, exp);
            else n_pass++;
        end
        Wdata = 8'h99;
        step();
        wr = 1'b0;
        got = {s_full, s_ovf, s_unf};
        n_total++;
        if (got !== 3'b110 || s_count !== 4'd8)
            $display("FAIL overflow_9th got=%b cnt=%0d want=110 cnt=8",
                     got, s_count);
        else n_pass++;
        n_total++;
        if (f_count !== 4'd8 || f_ovf !== 1'b1 || f_rdata !== 8'h11)
            $display("FAIL fwft_full got cnt=%0d ovf=%b rd=%h want 8 1 11",
                     f_count, f_ovf, f_rdata);
        else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            step();
            n_total++;
            if (s_rdata !== 8'h11 + 8'(i))
                $display("FAIL drain_data[%0d] got=%h want=%h",
                         i, s_rdata, 8'h11 + 8'(i));
            else n_pass++;
            n_total++;
            if (s_count !== 4'(7 - i) || s_empty !== (i == 7))
                $display("FAIL drain_state[%0d] cnt=%0d e=%b want %0d %b",
                         i, s_count, s_empty, 7 - i, (i == 7));
            else n_pass++;
            if (i < 7) begin
                n_total++;
                if (f_rdata !== 8'h12 + 8'(i))
                    $display("FAIL fwft_drain[%0d] got=%h want=%h",
                             i, f_rdata, 8'h12 + 8'(i));
                else n_pass++;
            end
        end
        step();
        rd = 1'b0;
        n_total++;
        if (s_unf !== 1'b1 || s_ovf !== 1'b1 || s_rdata !== 8'h18)
            $display("FAIL underflow_9th unf=%b ovf=%b rd=%h want 1 1 18",
                     s_unf, s_ovf, s_rdata);
        else n_pass++;
        n_total++;
        if (f_unf !== 1'b1 || f_empty !== 1'b1)
            $display("FAIL fwft_underflow unf=%b e=%b want 1 1",
                     f_unf, f_empty);
        else n_pass++;
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_total++;
        if ({s_ovf, s_unf, f_ovf, f_unf} !== 4'b0000)
            $display("FAIL clr_err got=%b want=0000",
                     {s_ovf, s_unf, f_ovf, f_unf});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1;
            Wdata = 8'h20 + 8'(i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            wr = 1'b1;
            rd = 1'b1;
            Wdata = 8'h24 + 8'(i);
            step();
            n_total++;
            if (s_rdata !== 8'h20 + 8'(i) || s_count !== 4'd4)
                $display("FAIL b2b[%0d] rd=%h cnt=%0d want %h 4",
                         i, s_rdata, s_count, 8'h20 + 8'(i));
            else n_pass++;
        end
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic test_fwft_single();
        do_reset();
        wr = 1'b1;
        Wdata = 8'hA5;
        step();
        wr = 1'b0;
        n_total++;
        if (f_empty !== 1'b1)
            $display("FAIL fwft_lat_n got empty=%b want 1", f_empty);
        else n_pass++;
        step();
        n_total++;
        if (f_empty !== 1'b0 || f_rdata !== 8'hA5 || f_count !== 4'd1)
            $display("FAIL fwft_lat_n1 e=%b rd=%h cnt=%0d want 0 a5 1",
                     f_empty, f_rdata, f_count);
        else n_pass++;
        rd = 1'b1;
        step();
        rd = 1'b0;
        n_total++;
        if (f_empty !== 1'b1 || f_count !== 4'd0 || f_unf !== 1'b0)
            $display("FAIL fwft_pop e=%b cnt=%0d unf=%b want 1 0 0",
                     f_empty, f_count, f_unf);
        else n_pass++;
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1;
            Wdata = 8'h30 + 8'(i);
            step();
        end
        Wdata = 8'hEE;
        rd = 1'b1;
        step();
        wr = 1'b0;
        rd = 1'b0;
        n_total++;
        if (s_count !== 4'd7 || s_ovf !== 1'b1 || s_full !== 1'b0)
            $display("FAIL full_rw cnt=%0d ovf=%b full=%b want 7 1 0",
                     s_count, s_ovf, s_full);
        else n_pass++;
        n_total++;
        if (s_rdata !== 8'h30 || s_af !== 1'b1)
            $display("FAIL full_rw_data rd=%h af=%b want 30 1",
                     s_rdata, s_af);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1;
            Wdata = 8'h40 + 8'(i);
            step();
        end
        rd = 1'b1;
        step();
        n_total++;
        if (s_count !== 4'd5 || s_rdata !== 8'h40)
            $display("FAIL mid_pre cnt=%0d rd=%h want 5 40",
                     s_count, s_rdata);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({s_full, s_empty, s_af, s_ae} !== 4'b0101 ||
            s_count !== 4'd0 || s_rdata !== 8'h00)
            $display("FAIL mid_reset fl=%b cnt=%0d rd=%h want 0101 0 00",
                     {s_full, s_empty, s_af, s_ae}, s_count, s_rdata);
        else n_pass++;
        n_total++;
        if (f_empty !== 1'b1 || f_count !== 4'd0 || f_rdata !== 8'h00)
            $display("FAIL mid_reset_fwft e=%b cnt=%0d rd=%h want 1 0 00",
                     f_empty, f_count, f_rdata);
        else n_pass++;
        wr = 1'b0;
        rd = 1'b0;
        step();
        rst = 1'b0;
        wr = 1'b1;
        Wdata = 8'h5A;
        step();
        wr = 1'b0;
        rd = 1'b1;
        step();
        rd = 1'b0;
        n_total++;
        if (s_rdata !== 8'h5A || s_empty !== 1'b1 || s_count !== 4'd0)
            $display("FAIL mid_after rd=%h e=%b cnt=%0d want 5a 1 0",
                     s_rdata, s_empty, s_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_fwft_single();
        test_full_rw();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of our FIFO storage. It adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and consumer in the same clock domain and wraps a registered-read dual-port RAM sub-module.

## Interface
- DATAWIDTH, 8, word width in bits.
- DEPTH, 8, number of words; power of two, at least 2.
- ADDR, $clog2(DEPTH), RAM address width; derived, not overridden.
- AFULL_TH, DEPTH-1, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 1, almost_empty asserts when count <= AEMPTY_TH.
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write request.
- Wdata  in  DATAWIDTH  write data.
- rd  in  1  read/pop request.
- Rdata  out  DATAWIDTH  read data (registered).
- full  out  1  count == DEPTH.
- empty  out  1  no word available to read.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR+1  words held.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

## Operation
- Write accepted iff wr && !full. Read accepted iff rd && !empty. A rejected request changes no state except the error flags.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- When full with wr && rd both high, the read is accepted and the write is rejected (overflow set). When empty with both high, the write is accepted and the read is rejected (underflow set).
- Pointers are ADDR+1 bits, binary, and wrap naturally. RAM index is ptr[ADDR-1:0].
- count is registered: count_next = count + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- full, almost_full and almost_empty are registered from count_next. They are never combinational from the request inputs.
- Standard mode (FWFT=0):
  - empty = (count == 0).
  - Rdata is updated only on an accepted read and holds its value otherwise.
- FWFT mode (FWFT=1):
  - An output stage holds the head word; empty = !out_valid.
  - When the output stage is empty, or is being popped, and the RAM holds data, the RAM is read to prefetch the next word.
  - count includes the word in the output stage.
- Error flags: set on a rejected request and held until clr_err. If set and clr_err coincide, set wins.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, count and Rdata go to 0; out_valid = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
  - RAM contents are not reset and are unreachable after reset.

## Timing
- Standard read latency: rd accepted at edge N gives Rdata valid after edge N.
- Standard write to flag: write at edge N into an empty FIFO deasserts empty after edge N.
- FWFT: write at edge N into an empty FIFO gives Rdata = word and empty = 0 after edge N+1.
- FWFT: a pop at edge N presents the next word after edge N when it is already prefetched, otherwise after N+1. Back-to-back pops sustain 1 word per cycle.
- Throughput: 1 write and 1 read per cycle.
- full deasserts the edge after the first accepted read from full.

## Structure
- Shared package fifo_pkg holds:
  - FIFO_STD = 0 and FIFO_FWFT = 1 mode constants.
  - A count-width function (clog2(DEPTH)+1).
- Sub-module sync_dp_ram: single clock, one write port, one read port with registered read (read enable, address, data out), no reset on the array.

## Test plan
- Reset, then write 0x11..0x18 with DEPTH=8, FWFT=0:
  - full after the 8th write, count=8, almost_full after the 7th.
  - A 9th write sets overflow and leaves count=8.
- Read all 8 words: Rdata sequence 0x11..0x18, each valid the cycle after rd. empty after the 8th read. A 9th read sets underflow. clr_err clears both flags.
- Simultaneous rd and wr at count=4 for 20 cycles with pointer wrap: count stays 4 and data order is preserved.
- FWFT=1, single write 0xA5 into empty: Rdata=0xA5 and empty=0 two edges after wr. rd then pops it and empty=1.
- Full FIFO with wr && rd high: read accepted, write rejected, overflow=1, count=7.
- Assert rst mid-burst at count=5: all outputs return to their reset values immediately. The next write/read returns the newly written data.
